// File: rtl/mont_pkg.sv
// Shared constants and FSM state encoding for the digit-serial Montgomery multiplier control path.
package mont_pkg;
  localparam int SIZE       = 3072;
  localparam int RADIX      = 72;
  localparam int SIZE_LOG   = 6;
  localparam int NUM_DIGITS = 43;
  localparam int CNT_W      = 6;
  localparam int ACC_W      = SIZE + RADIX + SIZE_LOG;
  localparam int BSH_W      = NUM_DIGITS * RADIX;
  localparam int PROD_W     = 2 * SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} seq_state_e;
endpackage

// File: rtl/mont_digit_shifter.sv
// Holds the zero-padded b operand and the collected low product digits; both shift one digit per step.
module mont_digit_shifter
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [SIZE-1:0]  b_in,
  input  logic [RADIX-1:0] c_lo,
  output logic [RADIX-1:0] digit_next,
  output logic [BSH_W-1:0] low
);
  logic [BSH_W-1:0] b_sh_d, b_sh_q;
  logic [BSH_W-1:0] low_d, low_q;

  always_comb begin
    b_sh_d = b_sh_q;
    low_d  = low_q;
    if (load) begin
      b_sh_d = BSH_W'(b_in);
      low_d  = '0;
    end else if (shift) begin
      b_sh_d = b_sh_q >> RADIX;
      low_d  = {c_lo, low_q[BSH_W-1:RADIX]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_sh_q <= '0;
      low_q  <= '0;
    end else begin
      b_sh_q <= b_sh_d;
      low_q  <= low_d;
    end
  end

  // Digit that becomes current once the pending shift lands.
  assign digit_next = b_sh_q[2*RADIX-1:RADIX];
  assign low        = low_q;
endmodule

// File: rtl/mont_digit_sequencer.sv
// Outer-loop controller: issues one multiply-accumulate per b digit and assembles the 2*SIZE product.
// Optional wait watchdog with sticky err output: define MONT_SEQ_WATCHDOG_EN.
module mont_digit_sequencer
  import mont_pkg::*;
`ifdef MONT_SEQ_WATCHDOG_EN
#(
  parameter int WD_LIMIT = 255
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a_in,
  input  logic [SIZE-1:0]   b_in,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  stg_c,
  output logic [SIZE-1:0]   stg_a,
  output logic [RADIX-1:0]  stg_bi,
  output logic              stg_en,
`ifdef MONT_SEQ_WATCHDOG_EN
  output logic              err,
`endif
  input  logic [ACC_W-1:0]  stg_new_c,
  input  logic              stg_en_out
);
  seq_state_e        state_q;
  logic [SIZE-1:0]   a_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  dcnt_q;
  logic [RADIX-1:0]  bi_q;
  logic              en_q, busy_q, done_q;
  logic [PROD_W-1:0] product_q;
  logic              accept, step, last;
  logic [RADIX-1:0]  digit_next;
  logic [BSH_W-1:0]  low;

  // A start landing in the done cycle is treated as overlapping the finish and dropped.
  assign accept = (state_q == IDLE) && start && !done_q;
  assign step   = (state_q == WAIT) && stg_en_out;
  assign last   = (dcnt_q == CNT_W'(NUM_DIGITS - 1));

`ifdef MONT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wcnt_q;
  logic            err_q;
  assign err = err_q;
`endif

  mont_digit_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .shift      (step),
    .b_in       (b_in),
    .c_lo       (stg_new_c[RADIX-1:0]),
    .digit_next (digit_next),
    .low        (low)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      bi_q      <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MONT_SEQ_WATCHDOG_EN
      wcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          a_q     <= a_in;
          acc_q   <= '0;
          dcnt_q  <= '0;
          bi_q    <= b_in[RADIX-1:0];
          en_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
`ifdef MONT_SEQ_WATCHDOG_EN
          err_q   <= 1'b0;
`endif
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef MONT_SEQ_WATCHDOG_EN
          wcnt_q  <= '0;
`endif
        end
        WAIT: if (stg_en_out) begin
          acc_q  <= stg_new_c >> RADIX;
          dcnt_q <= dcnt_q + CNT_W'(1);
          if (last) begin
            state_q <= FIN;
          end else begin
            state_q <= ISSUE;
            en_q    <= 1'b1;
            bi_q    <= digit_next;
          end
        end
`ifdef MONT_SEQ_WATCHDOG_EN
        else if (wcnt_q == WD_W'(WD_LIMIT - 1)) begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          wcnt_q <= wcnt_q + WD_W'(1);
        end
`endif
        FIN: begin
          // Final accumulator sits above the collected low digits.
          product_q <= PROD_W'({acc_q, low});
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign stg_c   = acc_q;
  assign stg_a   = a_q;
  assign stg_bi  = bi_q;
  assign stg_en  = en_q;
endmodule

// File: tb/tb_mont_digit_sequencer.sv
// Bench for mont_digit_sequencer: behavioural stage model plus full-width product reference.
module tb_mont_digit_sequencer;
  import mont_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [SIZE-1:0]   a_in = '0, b_in = '0;
  logic              busy, done, stg_en;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  stg_c;
  logic [ACC_W-1:0]  stg_new_c = '0;
  logic [SIZE-1:0]   stg_a;
  logic [RADIX-1:0]  stg_bi;
  logic              stg_en_out = 1'b0;
`ifdef MONT_SEQ_WATCHDOG_EN
  logic              err;
`endif

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0, en_cnt = 0;
  int lat_fixed = 17;
  bit lat_rand = 1'b0, mute = 1'b0, spur = 1'b0;
  localparam int LAT17 = NUM_DIGITS * (17 + 2) + 2;

  mont_digit_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .stg_c(stg_c), .stg_a(stg_a), .stg_bi(stg_bi), .stg_en(stg_en),
`ifdef MONT_SEQ_WATCHDOG_EN
    .err(err),
`endif
    .stg_new_c(stg_new_c), .stg_en_out(stg_en_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Stage model: new_c = c + a*bi, result pulse L cycles after the issue is registered.
  initial begin : stage_model
    logic [ACC_W-1:0]  mc;
    logic [SIZE-1:0]   ma;
    logic [RADIX-1:0]  mb;
    int l;
    forever begin
      @(negedge clk);
      if (stg_en === 1'b1) begin
        mc = stg_c; ma = stg_a; mb = stg_bi;
        en_cnt++;
        n_chk++;
        if (mc[ACC_W-1:SIZE+RADIX+1] !== '0) begin
          n_fail++;
          $display("FAIL stg_c_bound digit %0d: top bits %b, required 0", en_cnt, mc[ACC_W-1:SIZE+RADIX+1]);
        end
        l = lat_rand ? int'($urandom_range(30, 1)) : lat_fixed;
        @(posedge clk); #1 stg_en_out = 1'b0;
        repeat (l) @(posedge clk);
        #1;
        if (!mute) begin
          n_chk++;
          if (stg_c !== mc || stg_a !== ma || stg_bi !== mb) begin
            n_fail++;
            $display("FAIL stg_hold digit %0d: bi %h required %h, c_lo %h required %h", en_cnt, stg_bi, mb, stg_c[63:0], mc[63:0]);
          end
          stg_new_c  = mc + ACC_W'(ma) * ACC_W'(mb);
          stg_en_out = 1'b1;
        end
        @(posedge clk); #1;
        if (spur && !mute) begin
          stg_new_c  = {ACC_W{1'b1}};
          stg_en_out = 1'b1;
          spur       = 1'b0;
        end else begin
          stg_en_out = 1'b0;
        end
      end
    end
  end

  function automatic logic [SIZE-1:0] rnd_wide();
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    @(posedge clk); #1;
    a_in = a; b_in = b; start = 1'b1; en_cnt = 0; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic wait_digits(input int n);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (en_cnt >= n) break;
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || stg_en !== 1'b0 || product !== '0 ||
        stg_c !== '0 || stg_a !== '0 || stg_bi !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b prod_lo=%h, required all 0", busy, done, stg_en, product[63:0]);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || stg_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b en=%b, required 0 0", busy, stg_en);
    end
  endtask

  task automatic test_unit;
    bit tmo;
    int lat;
    lat_fixed = 17; lat_rand = 1'b0;
    launch(SIZE'(1), SIZE'(1));
    wait_done(tmo);
    lat = cyc - t0;
    n_chk++;
    if (tmo) begin n_fail++; $display("FAIL unit_timeout: no done within bound"); end
    n_chk++;
    if (lat != LAT17) begin n_fail++; $display("FAIL unit_latency: got %0d cycles, required %0d", lat, LAT17); end
    n_chk++;
    if (en_cnt != NUM_DIGITS) begin n_fail++; $display("FAIL unit_issues: got %0d stg_en pulses, required %0d", en_cnt, NUM_DIGITS); end
    n_chk++;
    if (product !== PROD_W'(1)) begin n_fail++; $display("FAIL unit_product: got lo=%h, required 1", product[63:0]); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL unit_busy_fall: busy=%b in done cycle, required 0", busy); end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || product !== PROD_W'(1)) begin
      n_fail++;
      $display("FAIL unit_done_pulse: done=%b prod_lo=%h, required 0 and 1", done, product[63:0]);
    end
  endtask

  task automatic test_max;
    bit tmo;
    logic [SIZE-1:0]   a;
    logic [PROD_W-1:0] exp;
    a = '1;
    exp = PROD_W'(a) * PROD_W'(a);
    launch(a, a);
    wait_done(tmo);
    n_chk++;
    if (tmo || product !== exp) begin
      n_fail++;
      $display("FAIL max_product: tmo=%b got lo=%h hi=%h, required lo=%h hi=%h", tmo, product[63:0], product[PROD_W-1 -: 64], exp[63:0], exp[PROD_W-1 -: 64]);
    end
    n_chk++;
    if ($isunknown(product)) begin n_fail++; $display("FAIL max_no_x: product has X/Z bits, required none"); end
  endtask

  task automatic test_digit1;
    bit tmo;
    logic [SIZE-1:0]   b;
    logic [PROD_W-1:0] exp;
    lat_rand = 1'b1;
    b   = SIZE'(1) << RADIX;
    exp = PROD_W'(16'h1234) << RADIX;
    for (int k = 0; k < 2; k++) begin
      launch(SIZE'(16'h1234), b);
      wait_done(tmo);
      n_chk++;
      if (tmo || product !== exp) begin
        n_fail++;
        $display("FAIL digit1_product run %0d: tmo=%b got lo=%h mid=%h, required lo=%h mid=%h", k, tmo, product[63:0], product[127:64], exp[63:0], exp[127:64]);
      end
    end
    lat_rand = 1'b0;
  endtask

  task automatic test_random;
    bit tmo;
    logic [SIZE-1:0]   a, b;
    logic [PROD_W-1:0] exp;
    lat_rand = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = rnd_wide();
      b = rnd_wide();
      if (k == 2) b = b & (SIZE'(64'hFFFF_FFFF_FFFF_FFFF) << (RADIX * 42));
      exp = PROD_W'(a) * PROD_W'(b);
      launch(a, b);
      wait_done(tmo);
      n_chk++;
      if (tmo || product !== exp) begin
        n_fail++;
        $display("FAIL random_product run %0d: tmo=%b got lo=%h hi=%h, required lo=%h hi=%h", k, tmo, product[63:0], product[PROD_W-1 -: 64], exp[63:0], exp[PROD_W-1 -: 64]);
      end
    end
    lat_rand = 1'b0;
  endtask

  task automatic test_start_busy;
    bit tmo;
    int lat;
    logic [SIZE-1:0]   a, b;
    logic [PROD_W-1:0] exp;
    a = rnd_wide(); b = rnd_wide();
    exp = PROD_W'(a) * PROD_W'(b);
    launch(a, b);
    wait_digits(10);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    a_in = rnd_wide(); b_in = rnd_wide(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_digits(15);
    spur = 1'b1;
    wait_done(tmo);
    lat = cyc - t0;
    n_chk++;
    if (tmo || product !== exp) begin
      n_fail++;
      $display("FAIL busy_start_product: tmo=%b got lo=%h, required lo=%h", tmo, product[63:0], exp[63:0]);
    end
    n_chk++;
    if (lat != LAT17 || en_cnt != NUM_DIGITS) begin
      n_fail++;
      $display("FAIL busy_start_timing: %0d cycles %0d issues, required %0d and %0d", lat, en_cnt, LAT17, NUM_DIGITS);
    end
  endtask

  // start held high from launch through the done cycle; only the first edge may accept it.
  task automatic test_start_held;
    bit tmo, bad;
    int lat;
    @(posedge clk); #1;
    a_in = SIZE'(7); b_in = SIZE'(9); start = 1'b1; en_cnt = 0; t0 = cyc;
    @(posedge clk); #1;
    a_in = rnd_wide(); b_in = rnd_wide();
    wait_done(tmo);
    lat = cyc - t0;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || stg_en !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (tmo || product !== PROD_W'(63) || lat != LAT17) begin
      n_fail++;
      $display("FAIL held_start_product: tmo=%b lo=%h lat=%0d, required 3f and %0d", tmo, product[63:0], lat, LAT17);
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL held_start_at_done: restarted after done, required stay idle"); end
  endtask

  task automatic test_reset_mid;
    bit tmo, bad;
    launch(rnd_wide(), rnd_wide());
    wait_digits(20);
    repeat (5) @(negedge clk);
    mute  = 1'b1;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || stg_en !== 1'b0 || product !== '0 ||
        stg_c !== '0 || stg_a !== '0 || stg_bi !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b en=%b c_lo=%h prod_lo=%h, required all 0", busy, stg_en, stg_c[63:0], product[63:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    stg_new_c = {ACC_W{1'b1}}; stg_en_out = 1'b1;
    @(posedge clk); #1;
    stg_en_out = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || stg_en !== 1'b0 || product !== '0 || stg_c !== '0) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL midreset_stale: state moved on stale stg_en_out, required idle with zero outputs"); end
    mute = 1'b0;
    launch(SIZE'(3), SIZE'(5));
    wait_done(tmo);
    n_chk++;
    if (tmo || product !== PROD_W'(15) || (cyc - t0) != LAT17) begin
      n_fail++;
      $display("FAIL midreset_fresh: tmo=%b lo=%h lat=%0d, required f and %0d", tmo, product[63:0], cyc - t0, LAT17);
    end
  endtask

`ifdef MONT_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    bit tmo, saw_done;
    mute = 1'b1;
    launch(SIZE'(5), SIZE'(7));
    for (int i = 0; i < 100; i++) begin
      if (stg_en === 1'b1) break;
      @(negedge clk);
    end
    saw_done = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (k == 255) begin
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_early: err=%b busy=%b after 254 waits, required 0 1", err, busy); end
      end
      if (k == 256) begin
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_trip: err=%b busy=%b after 255 waits, required 1 0", err, busy); end
      end
    end
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done || product !== PROD_W'(15) || err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_abort: done_seen=%b prod_lo=%h err=%b, required 0 f 1", saw_done, product[63:0], err);
    end
    mute = 1'b0;
    repeat (30) @(negedge clk);
    launch(SIZE'(6), SIZE'(7));
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wd_clear: err=%b after new start, required 0", err); end
    wait_done(tmo);
    n_chk++;
    if (tmo || product !== PROD_W'(42)) begin n_fail++; $display("FAIL wd_recover: tmo=%b lo=%h, required 2a", tmo, product[63:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_unit();
    test_max();
    test_digit1();
    test_random();
    test_start_busy();
    test_start_held();
    test_reset_mid();
`ifdef MONT_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
